wind_conditioner: RTL
=====================

Name: wind_conditioner

Overview:
- Upstream stage for the runway-lights pattern FSM.
- Turns the two raw, asynchronous wind switches into a clean 2-bit wind code and a one-cycle step strobe, so the pattern FSM advances at a visible rate.
- Synchronizes and debounces the switches, rejects the illegal code 2'b11, and presents a wind value that is held constant between steps.

Parameters:
- DEBOUNCE_CYCLES, 4: extra consecutive cycles a synchronized value must persist before it is accepted; must be >=1.
- STEP_PERIOD, 8: clock cycles between step strobes; must be >=2. Board builds override with a large value.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- sw_wind  input  2  raw switch levels, asynchronous to clk. 00 calm, 01 wind from right, 10 wind from left, 11 illegal.
- wind  output  2  conditioned legal wind code; changes only on step edges.
- step  output  1  registered one-cycle advance strobe for the pattern FSM.
- illegal  output  1  high while the debounced switch value is 2'b11.

Behaviour:
- Reset, reset low, asynchronous and immediate:
  - Sync flops, candidate, debounce counter, stable value, last_legal, step counter, wind and step all clear to 0.
  - Outputs during reset: wind=00, step=0, illegal=0.
  - Reset asserted mid-operation aborts any debounce in progress and restarts the step period from 0.
- Synchronizer: two-flop chain per bit. sync_q is the second-stage output.
- Debounce, per cycle:
  - If sync_q != candidate: candidate <= sync_q, dcnt <= 0.
  - Else if dcnt < DEBOUNCE_CYCLES-1: dcnt <= dcnt+1.
  - Else (match and dcnt saturated): stable <= candidate.
  - A new sync_q value must persist DEBOUNCE_CYCLES+1 consecutive cycles to be accepted.
  - A new raw value held steadily is reflected in stable exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it (7 with default).
  - Any shorter pulse is discarded and stable is unchanged.
  - dcnt width is clog2(DEBOUNCE_CYCLES), minimum 1 bit.
- Illegal filter:
  - illegal = (stable == 2'b11), decoded combinationally from the stable register.
  - last_legal <= stable every cycle that stable != 2'b11; otherwise last_legal holds.
- Step generator:
  - scnt is free-running 0..STEP_PERIOD-1 and wraps to 0.
  - On the edge where scnt == STEP_PERIOD-1: step <= 1 and wind <= last_legal.
  - On all other edges: step <= 0 and wind holds.
  - step is therefore high for exactly one cycle every STEP_PERIOD cycles. The first step cycle follows the STEP_PERIOD-th rising edge after reset deasserts.
  - wind is constant for a full period and already carries the new value during the step cycle. The consumer samples wind on the edge that ends the step cycle.
- Simultaneous events:
  - If last_legal updates on the same edge as a step load, wind takes the old last_legal (pre-edge value).
  - The new value appears at the next step.
- No backpressure: step is never stalled and is never suppressed by illegal.

Test Plan (DEBOUNCE_CYCLES=4, STEP_PERIOD=8):
1. Hold reset low 3 cycles with sw_wind=10, then release -> wind=00, step=0, illegal=0 during reset. step is high only in the cycles after edges 8, 16, 24 post-release; never two consecutive cycles.
2. From calm, set sw_wind=01 steadily -> stable=01 after 7 edges. wind becomes 01 at the next step-load edge, not before, and holds 01 for the full 8-cycle period.
3. Glitch: sw_wind=10 for 4 cycles, then back to 00 -> stable, wind and illegal unchanged throughout.
4. With wind=01, set sw_wind=11 steadily -> illegal rises exactly 7 edges later, and wind stays 01 across the next 3 steps. Return to 00 -> illegal falls 7 edges later, and wind=00 at the following step.
5. Drop reset asynchronously between clock edges mid-period while wind=10 -> wind=00 and step=0 immediately, without a clock edge. After release, the first step comes 8 edges later.
6. Change sw_wind 01->10 so stable updates on the same edge as a step load -> that step shows 01, and the next step shows 10.

Source files
------------

// File: rtl/wind_conditioner.sv
// Purpose : conditions two raw async wind switches into a legal 2-bit wind code plus a periodic step strobe.
// Latency : steady raw change reaches the debounced value after DEBOUNCE_CYCLES+3 edges; wind follows at the next step load.
// Backpressure: none; step fires every STEP_PERIOD cycles unconditionally and is never gated by illegal.
//
// Ports:
//   clk      in   system clock, rising-edge active
//   reset    in   asynchronous active-low reset
//   sw_wind  in   [1:0] raw switch levels (00 calm, 01 from right, 10 from left, 11 illegal)
//   wind     out  [1:0] last legal debounced code, reloaded only on step edges
//   step     out  registered one-cycle advance strobe
//   illegal  out  high while the debounced value is 2'b11
module wind_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_PERIOD     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_wind,
  output logic [1:0] wind,
  output logic       step,
  output logic       illegal
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;

  localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCNT_MAX = SW'(STEP_PERIOD - 1);

  logic [1:0]    sync_d;
  logic [1:0]    sync_q;
  logic [1:0]    candidate;
  logic [DW-1:0] dcnt;
  logic [1:0]    stable;
  logic [1:0]    last_legal;
  logic [SW-1:0] scnt;

  // Two-flop synchronizer per bit; sync_q is the first value safe to use.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_d <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      sync_d <= sw_wind;
      sync_q <= sync_d;
    end
  end

  // Debounce: a new value first becomes the candidate, then must keep
  // matching until dcnt saturates before it is copied into stable.
  // Any mismatch restarts the count against the newer value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      candidate <= 2'b00;
      dcnt      <= '0;
      stable    <= 2'b00;
    end else if (sync_q != candidate) begin
      candidate <= sync_q;
      dcnt      <= '0;
    end else if (dcnt < DCNT_MAX) begin
      dcnt <= dcnt + DW'(1);
    end else begin
      stable <= candidate;
    end
  end

  assign illegal = (stable == 2'b11);

  // Remember the most recent legal debounced code so an illegal setting
  // freezes the presented wind rather than passing 11 downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_legal <= 2'b00;
    end else if (stable != 2'b11) begin
      last_legal <= stable;
    end
  end

  // Step generator: free-running period counter. wind is reloaded on the
  // same edge that raises step, so the consumer sees the new code during
  // the step cycle and samples it on the edge that ends it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt <= '0;
      step <= 1'b0;
      wind <= 2'b00;
    end else if (scnt == SCNT_MAX) begin
      scnt <= '0;
      step <= 1'b1;
      wind <= last_legal;
    end else begin
      scnt <= scnt + SW'(1);
      step <= 1'b0;
    end
  end

endmodule
